// File: rtl/pipe_pkg.sv
// Shared definitions for the cpu55 ID stage: default geometry, control
// bundle width and the operand-source encoding used by the forwarding muxes.
package pipe_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREG_DEF   = 32;
  localparam int CTRL_W_DEF = 24;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/pipe_id_hz_if.sv
// Bundle of all fetch / control-unit / EX / MEM / WB signals seen by the
// ID stage. The master side is the surrounding pipeline, the slave side is
// the ID stage itself.
interface pipe_id_hz_if
  import pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int CTRL_W = CTRL_W_DEF
);
  localparam int AW = $clog2(NREG);

  logic              if_valid;
  logic [31:0]       if_instr;
  logic [XLEN-1:0]   if_pc;
  logic              id_ready;
  logic [CTRL_W-1:0] cu_ctrl;
  logic              cu_uses_rs;
  logic              cu_uses_rt;
  logic              cu_load;
  logic              cu_wrf;
  logic [AW-1:0]     cu_wa;
  logic              flush;
  logic              ex_ready;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_rd1;
  logic [XLEN-1:0]   ex_rd2;
  logic [AW-1:0]     ex_wa;
  logic              ex_wrf;
  logic              ex_load;
  logic [XLEN-1:0]   ex_fwd_wd;
  logic              mem_wen;
  logic [AW-1:0]     mem_wa;
  logic [XLEN-1:0]   mem_wd;
  logic              wb_wen;
  logic [AW-1:0]     wb_wa;
  logic [XLEN-1:0]   wb_wd;
  logic              wb_ovf;

  modport master (
    output if_valid, if_instr, if_pc, cu_ctrl, cu_uses_rs, cu_uses_rt,
           cu_load, cu_wrf, cu_wa, flush, ex_ready, ex_fwd_wd,
           mem_wen, mem_wa, mem_wd, wb_wen, wb_wa, wb_wd, wb_ovf,
    input  id_ready, ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_wa,
           ex_wrf, ex_load
  );

  modport slave (
    input  if_valid, if_instr, if_pc, cu_ctrl, cu_uses_rs, cu_uses_rt,
           cu_load, cu_wrf, cu_wa, flush, ex_ready, ex_fwd_wd,
           mem_wen, mem_wa, mem_wd, wb_wen, wb_wa, wb_wd, wb_ovf,
    output id_ready, ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_wa,
           ex_wrf, ex_load
  );

endinterface

// File: rtl/pipe_id_rf.sv
// Architectural register file: NREG x XLEN, two combinational read ports,
// one write port, register 0 reads as zero, and a write-before-read bypass
// so a read of the register being written this cycle sees the new value.
module pipe_id_rf #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [AW-1:0]   i_ra1,
  input  logic [AW-1:0]   i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_wr;

  // Register 0 is never written, so its reset value of zero sticks.
  assign w_wr = i_we & (i_wa != '0);

  // Write port, with the whole file cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == '0)             ? '0   :
                 (w_wr && i_ra1 == i_wa)   ? i_wd : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == '0)             ? '0   :
                 (w_wr && i_ra2 == i_wa)   ? i_wd : r_regs[i_ra2];

endmodule

// File: rtl/pipe_id_hz.sv
// cpu55 instruction-decode stage: register-file read, hazard detection,
// operand forwarding and the ID/EX pipeline register.
// Build option: PIPE_ID_FWD_EN enables the EX/MEM forwarding paths; without
// it every EX or MEM register hazard stalls until the value is in the file.
module pipe_id_hz
  import pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input logic         clk,
  input logic         rst,
  pipe_id_hz_if.slave io_bus
);
  localparam int AW = $clog2(NREG);

  logic              r_vld_p1, r_wrf_p1, r_load_p1;
  logic [CTRL_W-1:0] r_ctrl_p1;
  logic [XLEN-1:0]   r_pc_p1, r_rd1_p1, r_rd2_p1;
  logic [AW-1:0]     r_wa_p1;

  logic [AW-1:0]   w_rs, w_rt;
  logic [XLEN-1:0] w_rf_rd1, w_rf_rd2, w_op1, w_op2;
  logic            w_ex_live, w_mem_live;
  logic            w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2;
  logic            w_stall, w_adv, w_unused;

  assign w_rs = io_bus.if_instr[21 +: AW];
  assign w_rt = io_bus.if_instr[16 +: AW];

  pipe_id_rf #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_we  (io_bus.wb_wen & ~io_bus.wb_ovf),
    .i_wa  (io_bus.wb_wa),
    .i_wd  (io_bus.wb_wd),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .o_rd1 (w_rf_rd1),
    .o_rd2 (w_rf_rd2)
  );

  // A producer only matters if it is live and targets a real register.
  assign w_ex_live  = r_vld_p1 & r_wrf_p1 & (r_wa_p1 != '0);
  assign w_mem_live = io_bus.mem_wen & (io_bus.mem_wa != '0);
  assign w_ex_hit1  = w_ex_live  & io_bus.cu_uses_rs & (w_rs == r_wa_p1);
  assign w_ex_hit2  = w_ex_live  & io_bus.cu_uses_rt & (w_rt == r_wa_p1);
  assign w_mem_hit1 = w_mem_live & io_bus.cu_uses_rs & (w_rs == io_bus.mem_wa);
  assign w_mem_hit2 = w_mem_live & io_bus.cu_uses_rt & (w_rt == io_bus.mem_wa);

`ifdef PIPE_ID_FWD_EN
  // EX beats MEM beats the file; a load in EX has no value yet and stalls.
  function automatic fwd_sel_t f_fwd_sel(input logic ex_hit, input logic ex_load,
                                         input logic mem_hit);
    if (ex_hit && !ex_load) return FWD_EX;
    if (mem_hit)            return FWD_MEM;
    return FWD_RF;
  endfunction

  function automatic logic [XLEN-1:0] f_fwd_mux(input fwd_sel_t sel,
                                                input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] ex,
                                                input logic [XLEN-1:0] mem);
    case (sel)
      FWD_EX:  return ex;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

  fwd_sel_t w_sel1, w_sel2;
  assign w_stall  = (w_ex_hit1 | w_ex_hit2) & r_load_p1;
  assign w_sel1   = f_fwd_sel(w_ex_hit1, r_load_p1, w_mem_hit1);
  assign w_sel2   = f_fwd_sel(w_ex_hit2, r_load_p1, w_mem_hit2);
  assign w_op1    = f_fwd_mux(w_sel1, w_rf_rd1, io_bus.ex_fwd_wd, io_bus.mem_wd);
  assign w_op2    = f_fwd_mux(w_sel2, w_rf_rd2, io_bus.ex_fwd_wd, io_bus.mem_wd);
  assign w_unused = ^io_bus.if_instr;
`else
  // No bypass network: wait until the producer has reached write-back.
  assign w_stall  = w_ex_hit1 | w_ex_hit2 | w_mem_hit1 | w_mem_hit2;
  assign w_op1    = w_rf_rd1;
  assign w_op2    = w_rf_rd2;
  assign w_unused = ^{io_bus.if_instr, io_bus.ex_fwd_wd, io_bus.mem_wd};
`endif

  assign w_adv           = io_bus.ex_ready | ~r_vld_p1;
  assign io_bus.id_ready = (~w_stall & w_adv) | io_bus.flush;

  // ID -> EX boundary: flush kills, a stalled advance inserts a bubble,
  // otherwise the decoded instruction moves forward or everything holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld_p1  <= 1'b0;
      r_wrf_p1  <= 1'b0;
      r_load_p1 <= 1'b0;
      r_ctrl_p1 <= '0;
      r_pc_p1   <= '0;
      r_rd1_p1  <= '0;
      r_rd2_p1  <= '0;
      r_wa_p1   <= '0;
    end else if (io_bus.flush) begin
      r_vld_p1  <= 1'b0;
      r_wrf_p1  <= 1'b0;
      r_load_p1 <= 1'b0;
    end else if (w_adv) begin
      if (w_stall) begin
        r_vld_p1  <= 1'b0;
        r_wrf_p1  <= 1'b0;
        r_load_p1 <= 1'b0;
      end else begin
        r_vld_p1  <= io_bus.if_valid;
        r_wrf_p1  <= io_bus.if_valid & io_bus.cu_wrf;
        r_load_p1 <= io_bus.if_valid & io_bus.cu_load;
        r_ctrl_p1 <= io_bus.cu_ctrl;
        r_pc_p1   <= io_bus.if_pc;
        r_rd1_p1  <= w_op1;
        r_rd2_p1  <= w_op2;
        r_wa_p1   <= io_bus.cu_wa;
      end
    end
  end

  assign io_bus.ex_valid = r_vld_p1;
  assign io_bus.ex_wrf   = r_wrf_p1;
  assign io_bus.ex_load  = r_load_p1;
  assign io_bus.ex_ctrl  = r_ctrl_p1;
  assign io_bus.ex_pc    = r_pc_p1;
  assign io_bus.ex_rd1   = r_rd1_p1;
  assign io_bus.ex_rd2   = r_rd2_p1;
  assign io_bus.ex_wa    = r_wa_p1;

endmodule

// File: tb/tb_pipe_id_hz.sv
// Bench for pipe_id_hz: directed vector table for the hazard scenarios, then
// randomized cycles against a behavioural model of the decode stage.
module tb_pipe_id_hz;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_id_hz_if bus_if ();
  pipe_id_hz dut (.clk(clk), .rst(rst), .io_bus(bus_if));

  typedef struct {
    logic rstn, iv, urs, urt, ld, wrf, flush, exr;
    logic mwen, wwen, wovf;
    logic [5:0]  op;
    logic [4:0]  rs, rt, wa, mwa, wwa;
    logic [15:0] imm;
    logic [23:0] ctrl;
    logic [31:0] pc, exfwd, mwd, wwd;
  } in_t;

  typedef struct {
    in_t i;
    logic rdy, vld, chk;
    logic [31:0] rd1, rd2;
  } vec_t;

  typedef struct {
    logic vld, wrf, ld;
    logic [4:0]  wa;
    logic [23:0] ctrl;
    logic [31:0] pc, rd1, rd2;
  } ex_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[$];
  ex_t  m_ex;
  logic [31:0] m_rf [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v = '{default: '0};
    v.rstn = 1'b1;
    v.exr  = 1'b1;
    v.op   = 6'($urandom);
    v.imm  = 16'($urandom);
    v.ctrl = 24'($urandom);
    v.pc   = $urandom;
    return v;
  endfunction

  function automatic in_t ins(input int rs, input int urs, input int rt, input int urt,
                              input int wrf, input int wa, input int ld);
    in_t v;
    v = idle();
    v.iv  = 1'b1;
    v.rs  = rs[4:0];
    v.urs = urs[0];
    v.rt  = rt[4:0];
    v.urt = urt[0];
    v.wrf = wrf[0];
    v.wa  = wa[4:0];
    v.ld  = ld[0];
    return v;
  endfunction

  function automatic in_t rnd();
    in_t v;
    v = idle();
    v.rstn  = ($urandom_range(0, 99) != 0);
    v.iv    = ($urandom_range(0, 3) != 0);
    v.rs    = 5'($urandom_range(0, 7));
    v.rt    = 5'($urandom_range(0, 7));
    v.wa    = 5'($urandom_range(0, 7));
    v.urs   = 1'($urandom);
    v.urt   = 1'($urandom);
    v.ld    = ($urandom_range(0, 3) == 0);
    v.wrf   = ($urandom_range(0, 3) != 0);
    v.flush = ($urandom_range(0, 15) == 0);
    v.exr   = ($urandom_range(0, 3) != 0);
    v.exfwd = $urandom;
    v.mwen  = 1'($urandom);
    v.mwa   = 5'($urandom_range(0, 7));
    v.mwd   = $urandom;
    v.wwen  = 1'($urandom);
    v.wovf  = ($urandom_range(0, 7) == 0);
    v.wwa   = 5'($urandom_range(0, 7));
    v.wwd   = $urandom;
    return v;
  endfunction

  task automatic add(input in_t i, input int rdy, input int vld, input int c,
                     input logic [31:0] rd1, input logic [31:0] rd2);
    vec_t e;
    e.i = i; e.rdy = (rdy != 0); e.vld = (vld != 0); e.chk = (c != 0);
    e.rd1 = rd1; e.rd2 = rd2;
    tbl.push_back(e);
  endtask

  // Model: register file read with write-before-read.
  function automatic logic [31:0] m_read(input in_t v, input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (v.wwen && !v.wovf && v.wwa == a) return v.wwd;
    return m_rf[a];
  endfunction

  function automatic logic m_exh(input logic [4:0] a, input logic u);
    return u && m_ex.vld && m_ex.wrf && m_ex.wa != 5'd0 && a == m_ex.wa;
  endfunction

  function automatic logic m_memh(input in_t v, input logic [4:0] a, input logic u);
    return u && v.mwen && v.mwa != 5'd0 && a == v.mwa;
  endfunction

  // One clock: drive, check id_ready before the edge, predict, check after.
  task automatic step(input in_t v, output logic rdy_seen);
    logic exh, stall, exp_rdy;
    logic [31:0] op1, op2;
    ex_t nx;
    bus_if.if_valid   = v.iv;
    bus_if.if_instr   = {v.op, v.rs, v.rt, v.imm};
    bus_if.if_pc      = v.pc;
    bus_if.cu_ctrl    = v.ctrl;
    bus_if.cu_uses_rs = v.urs;
    bus_if.cu_uses_rt = v.urt;
    bus_if.cu_load    = v.ld;
    bus_if.cu_wrf     = v.wrf;
    bus_if.cu_wa      = v.wa;
    bus_if.flush      = v.flush;
    bus_if.ex_ready   = v.exr;
    bus_if.ex_fwd_wd  = v.exfwd;
    bus_if.mem_wen    = v.mwen;
    bus_if.mem_wa     = v.mwa;
    bus_if.mem_wd     = v.mwd;
    bus_if.wb_wen     = v.wwen;
    bus_if.wb_wa      = v.wwa;
    bus_if.wb_wd      = v.wwd;
    bus_if.wb_ovf     = v.wovf;
    rst = v.rstn;
    #1;
    exh = m_exh(v.rs, v.urs) || m_exh(v.rt, v.urt);
    op1 = m_read(v, v.rs);
    op2 = m_read(v, v.rt);
`ifdef PIPE_ID_FWD_EN
    stall = exh && m_ex.ld;
    if (m_exh(v.rs, v.urs) && !m_ex.ld) op1 = v.exfwd;
    else if (m_memh(v, v.rs, v.urs))    op1 = v.mwd;
    if (m_exh(v.rt, v.urt) && !m_ex.ld) op2 = v.exfwd;
    else if (m_memh(v, v.rt, v.urt))    op2 = v.mwd;
`else
    stall = exh || m_memh(v, v.rs, v.urs) || m_memh(v, v.rt, v.urt);
`endif
    exp_rdy  = (!stall && (v.exr || !m_ex.vld)) || v.flush;
    rdy_seen = bus_if.id_ready;
    if (v.rstn) chk("id_ready", rdy_seen, exp_rdy);
    nx = m_ex;
    if (!v.rstn) begin
      nx = '{default: '0};
      for (int r = 0; r < 32; r++) m_rf[r] = 32'h0;
    end else begin
      if (v.flush || ((v.exr || !m_ex.vld) && stall)) begin
        nx.vld = 1'b0; nx.wrf = 1'b0; nx.ld = 1'b0;
      end else if (v.exr || !m_ex.vld) begin
        nx.vld = v.iv; nx.wrf = v.iv && v.wrf; nx.ld = v.iv && v.ld;
        nx.wa = v.wa; nx.ctrl = v.ctrl; nx.pc = v.pc; nx.rd1 = op1; nx.rd2 = op2;
      end
      if (v.wwen && !v.wovf && v.wwa != 5'd0) m_rf[v.wwa] = v.wwd;
    end
    @(posedge clk);
    #1;
    m_ex = nx;
    chk("ex_valid", bus_if.ex_valid, nx.vld);
    chk("ex_wrf", bus_if.ex_wrf, nx.wrf);
    chk("ex_load", bus_if.ex_load, nx.ld);
    if (nx.vld) begin
      chk("ex_ctrl", bus_if.ex_ctrl, nx.ctrl);
      chk("ex_pc", bus_if.ex_pc, nx.pc);
      chk("ex_wa", bus_if.ex_wa, nx.wa);
      chk("ex_rd1", bus_if.ex_rd1, nx.rd1);
      chk("ex_rd2", bus_if.ex_rd2, nx.rd2);
    end
  endtask

  initial begin
    in_t  v;
    logic r;
    m_ex = '{default: '0};
    for (int k = 0; k < 32; k++) m_rf[k] = 32'h0;

    // ALU result consumed by the next instruction.
    add(ins(1, 1, 2, 1, 1, 3, 0), 1, 1, 1, 32'h0, 32'h0);
`ifdef PIPE_ID_FWD_EN
    v = ins(3, 1, 0, 0, 0, 0, 0); v.exfwd = 32'h10;          add(v, 1, 1, 1, 32'h10, 32'h0);
    v = idle(); v.mwen = 1; v.mwa = 5'd3; v.mwd = 32'h10;    add(v, 1, 0, 0, 32'h0, 32'h0);
    v = idle(); v.wwen = 1; v.wwa = 5'd3; v.wwd = 32'h10;    add(v, 1, 0, 0, 32'h0, 32'h0);
`else
    v = ins(3, 1, 0, 0, 0, 0, 0); v.exfwd = 32'h10;          add(v, 0, 0, 0, 32'h0, 32'h0);
    v = ins(3, 1, 0, 0, 0, 0, 0); v.mwen = 1; v.mwa = 5'd3; v.mwd = 32'h10;
    add(v, 0, 0, 0, 32'h0, 32'h0);
    v = ins(3, 1, 0, 0, 0, 0, 0); v.wwen = 1; v.wwa = 5'd3; v.wwd = 32'h10;
    add(v, 1, 1, 1, 32'h10, 32'h0);
    add(idle(), 1, 0, 0, 32'h0, 32'h0);
`endif
    // Load-use on rt.
    add(ins(0, 1, 0, 0, 1, 5, 1), 1, 1, 1, 32'h0, 32'h0);
    v = ins(0, 0, 5, 1, 0, 0, 0);                            add(v, 0, 0, 0, 32'h0, 32'h0);
    v.mwen = 1; v.mwa = 5'd5; v.mwd = 32'hCAFE;
`ifdef PIPE_ID_FWD_EN
    add(v, 1, 1, 1, 32'h0, 32'hCAFE);
    v = idle(); v.wwen = 1; v.wwa = 5'd5; v.wwd = 32'hCAFE;  add(v, 1, 0, 0, 32'h0, 32'h0);
`else
    add(v, 0, 0, 0, 32'h0, 32'h0);
    v = ins(0, 0, 5, 1, 0, 0, 0); v.wwen = 1; v.wwa = 5'd5; v.wwd = 32'hCAFE;
    add(v, 1, 1, 1, 32'h0, 32'hCAFE);
    add(idle(), 1, 0, 0, 32'h0, 32'h0);
`endif
    // WB bypass.
    v = ins(7, 1, 0, 0, 0, 0, 0); v.wwen = 1; v.wwa = 5'd7; v.wwd = 32'h55;
    add(v, 1, 1, 1, 32'h55, 32'h0);
    add(idle(), 1, 0, 0, 32'h0, 32'h0);
    // Overflow-suppressed write and the zero register.
    v = idle(); v.wwen = 1; v.wwa = 5'd4; v.wwd = 32'h44;    add(v, 1, 0, 0, 32'h0, 32'h0);
    v = ins(4, 1, 0, 0, 0, 0, 0); v.wwen = 1; v.wovf = 1; v.wwa = 5'd4; v.wwd = 32'hDEAD;
    add(v, 1, 1, 1, 32'h44, 32'h0);
    add(ins(4, 1, 0, 0, 0, 0, 0), 1, 1, 1, 32'h44, 32'h0);
    v = ins(0, 1, 0, 1, 0, 0, 0); v.wwen = 1; v.wwa = 5'd0; v.wwd = 32'h99;
    add(v, 1, 1, 1, 32'h0, 32'h0);
    add(ins(0, 1, 0, 1, 0, 0, 0), 1, 1, 1, 32'h0, 32'h0);
    add(idle(), 1, 0, 0, 32'h0, 32'h0);
    // Flush during a load-use stall, then a normal instruction.
    add(ins(0, 1, 0, 0, 1, 6, 1), 1, 1, 1, 32'h0, 32'h0);
    v = ins(6, 1, 0, 0, 0, 0, 0); v.flush = 1;               add(v, 1, 0, 0, 32'h0, 32'h0);
    add(ins(3, 1, 0, 0, 0, 0, 0), 1, 1, 1, 32'h10, 32'h0);
    add(idle(), 1, 0, 0, 32'h0, 32'h0);
    // Stall while EX is not ready: hold, then bubble, then flush.
    add(ins(0, 1, 0, 0, 1, 8, 1), 1, 1, 1, 32'h0, 32'h0);
    v = ins(8, 1, 0, 0, 0, 0, 0); v.exr = 0;                 add(v, 0, 1, 0, 32'h0, 32'h0);
    v.exr = 1;                                               add(v, 0, 0, 0, 32'h0, 32'h0);
    v.flush = 1;                                             add(v, 1, 0, 0, 32'h0, 32'h0);
    add(idle(), 1, 0, 0, 32'h0, 32'h0);
    // Reset in the middle of a stall clears ID/EX and the register file.
    add(ins(0, 1, 0, 0, 1, 9, 1), 1, 1, 1, 32'h0, 32'h0);
    v = ins(9, 1, 0, 0, 0, 0, 0); v.rstn = 0;                add(v, 0, 0, 0, 32'h0, 32'h0);
    add(ins(3, 1, 0, 0, 0, 0, 0), 1, 1, 1, 32'h0, 32'h0);
    add(idle(), 1, 0, 0, 32'h0, 32'h0);

    v = idle(); v.rstn = 0;
    step(v, r);
    step(v, r);
    chk("rst_valid", bus_if.ex_valid, 32'h0);
    chk("rst_wrf", bus_if.ex_wrf, 32'h0);
    chk("rst_load", bus_if.ex_load, 32'h0);
    chk("rst_ctrl", bus_if.ex_ctrl, 32'h0);
    chk("rst_pc", bus_if.ex_pc, 32'h0);
    chk("rst_rd1", bus_if.ex_rd1, 32'h0);
    chk("rst_rd2", bus_if.ex_rd2, 32'h0);
    chk("rst_wa", bus_if.ex_wa, 32'h0);

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].i, r);
      chk($sformatf("tbl%0d_rdy", k), r, tbl[k].rdy);
      chk($sformatf("tbl%0d_vld", k), bus_if.ex_valid, tbl[k].vld);
      if (tbl[k].chk) begin
        chk($sformatf("tbl%0d_rd1", k), bus_if.ex_rd1, tbl[k].rd1);
        chk($sformatf("tbl%0d_rd2", k), bus_if.ex_rd2, tbl[k].rd2);
      end
    end

    for (int k = 0; k < 600; k++) step(rnd(), r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
